// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive frame checker.
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 next state, data consumed LSB first.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REF = reflect32(CRC_POLY);

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]};
            if (fb) begin
                c = c ^ POLY_REF;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length,
// streams frame bytes one cycle late so the last byte carries the verdict.
module gmii_rx_frame
    import gmii_rx_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rx_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_good,
    output logic [11:0] out_len,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);

    localparam logic [11:0] MIN_L = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L = 12'(MAX_LEN);

    state_t      state;
    logic [2:0]  pre_cnt;
    logic [7:0]  hold;
    logic [11:0] len;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic        err;
    logic        last;
    logic        good_now;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .d       (rx_data),
        .crc_out (crc_next)
    );

    // A frame ends on rx_dv falling or when one byte too many arrives.
    assign last     = !rx_dv || (len == MAX_L);
    assign good_now = !rx_dv && (crc == CRC_RESIDUE) && !err
                      && (len >= MIN_L) && (len <= MAX_L);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= DROP;
            pre_cnt    <= '0;
            hold       <= '0;
            len        <= '0;
            crc        <= CRC_INIT;
            err        <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_good   <= 1'b0;
            out_len    <= '0;
            frames_ok  <= '0;
            frames_bad <= '0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_good  <= 1'b0;
            out_len   <= '0;
            unique case (state)
                IDLE: begin
                    if (rx_dv) begin
                        if (rx_data == PREAMBLE_BYTE) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!rx_dv) begin
                        state <= IDLE;
                    end else if (rx_data == SFD_BYTE) begin
                        state <= DATA;
                        crc   <= CRC_INIT;
                        len   <= '0;
                        err   <= 1'b0;
                    end else if (rx_data == PREAMBLE_BYTE && pre_cnt != 3'd7) begin
                        pre_cnt <= pre_cnt + 3'd1;
                    end else begin
                        state <= DROP;
                    end
                end
                DATA: begin
                    if (len != 12'd0) begin
                        out_valid <= 1'b1;
                        out_data  <= hold;
                        out_sof   <= (len == 12'd1);
                    end
                    if (last) begin
                        state <= rx_dv ? DROP : IDLE;
                        if (len == 12'd0) begin
                            frames_bad <= frames_bad + 16'd1;
                        end else begin
                            out_eof  <= 1'b1;
                            out_good <= good_now;
                            out_len  <= len;
                            if (good_now) begin
                                frames_ok <= frames_ok + 16'd1;
                            end else begin
                                frames_bad <= frames_bad + 16'd1;
                            end
                        end
                    end else begin
                        hold <= rx_data;
                        crc  <= crc_next;
                        len  <= len + 12'd1;
                        err  <= err | rx_er;
                    end
                end
                DROP: begin
                    if (!rx_dv) begin
                        state <= IDLE;
                    end
                end
                default: state <= DROP;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Randomised self-checking bench for gmii_rx_frame against a frame-level model.
module tb_gmii_rx_frame;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    typedef logic [7:0] bq_t[$];

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        out_good;
    logic [11:0] out_len;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;

    int vectors = 0;
    int errors = 0;
    int exp_ok = 0;
    int exp_bad = 0;

    bq_t cap;
    int  sof_idx_q[$];
    int  eof_idx_q[$];
    int  eof_len_q[$];
    bit  eof_good_q[$];
    int  stray = 0;

    always #5 clock = ~clock;

    gmii_rx_frame #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_dv      (rx_dv),
        .rx_er      (rx_er),
        .rx_data    (rx_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .out_good   (out_good),
        .out_len    (out_len),
        .frames_ok  (frames_ok),
        .frames_bad (frames_bad)
    );

    // Monitor: record every emitted byte and its markers.
    always @(negedge clock) begin
        if (out_valid) begin
            if (out_sof) sof_idx_q.push_back(cap.size());
            if (out_eof) begin
                eof_idx_q.push_back(cap.size());
                eof_len_q.push_back(int'(out_len));
                eof_good_q.push_back(out_good);
            end
            cap.push_back(out_data);
        end else if (out_sof || out_eof || out_good) begin
            stray++;
        end
    end

    function automatic logic [31:0] crc_calc(bq_t b, int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit fcs_ok(bq_t b);
        int n = b.size();
        if (n < 4) return 1'b0;
        return crc_calc(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]};
    endfunction

    function automatic bq_t add_fcs(bq_t b);
        logic [31:0] c = crc_calc(b, b.size());
        b.push_back(c[7:0]);
        b.push_back(c[15:8]);
        b.push_back(c[23:16]);
        b.push_back(c[31:24]);
        return b;
    endfunction

    function automatic bq_t mk_raw(int n);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    function automatic bq_t arp_frame();
        bq_t b;
        b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h06,
              8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
              8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8, 8'h01, 8'h01,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h02};
        while (b.size() < 60) b.push_back(8'h00);
        b[50] = 8'hDE;
        return add_fcs(b);
    endfunction

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clock);
        #1;
        rx_dv = dv;
        rx_er = er;
        rx_data = d;
    endtask

    task automatic send(input bq_t b, input int er_at, input int gap);
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < b.size(); i++) drive(1'b1, i == er_at, b[i]);
        repeat (gap) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        repeat (3) drive(1'b1, 1'b0, 8'($urandom));
        @(negedge clock);
        vectors++;
        if ({out_valid, out_sof, out_eof, out_good, out_data, out_len} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {out_valid, out_sof, out_eof, out_good, out_data, out_len});
        end
        vectors++;
        if ({frames_ok, frames_bad} !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters: got ok=%0d bad=%0d want 0/0", frames_ok, frames_bad);
        end
        reset_n = 1'b1;
        repeat (30) drive(1'b1, 1'b0, 8'($urandom));
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        vectors++;
        if (cap.size() !== 0 || frames_ok !== 16'd0 || frames_bad !== 16'd0) begin
            errors++;
            $display("FAIL reset_midframe: got bytes=%0d ok=%0d bad=%0d want 0/0/0",
                     cap.size(), frames_ok, frames_bad);
        end
    endtask

    task automatic test_arp(input bit corrupt);
        bq_t f = arp_frame();
        int  base = cap.size();
        int  ne = eof_idx_q.size();
        int  ns = sof_idx_q.size();
        bit  eg;
        if (corrupt) f[50] = 8'hDF;
        eg = fcs_ok(f) && !corrupt;
        if (eg) exp_ok++; else exp_bad++;
        send(f, -1, 3);
        vectors++;
        if (cap.size() - base !== 64) begin
            errors++;
            $display("FAIL arp_count: got %0d want 64", cap.size() - base);
        end
        vectors++;
        if (sof_idx_q.size() - ns !== 1 || sof_idx_q[$] !== base || cap[base] !== 8'hFF) begin
            errors++;
            $display("FAIL arp_sof: got idx %0d want %0d", sof_idx_q[$], base);
        end
        vectors++;
        if (eof_idx_q.size() - ne !== 1 || eof_idx_q[$] !== base + 63) begin
            errors++;
            $display("FAIL arp_eof: got idx %0d want %0d", eof_idx_q[$], base + 63);
        end
        vectors++;
        if (eof_good_q[$] !== eg || eof_len_q[$] !== 64) begin
            errors++;
            $display("FAIL arp_verdict: got good=%0d len=%0d want %0d/64",
                     eof_good_q[$], eof_len_q[$], eg);
        end
        vectors++;
        if (int'(frames_ok) !== exp_ok || int'(frames_bad) !== exp_bad) begin
            errors++;
            $display("FAIL arp_counters: got %0d/%0d want %0d/%0d",
                     frames_ok, frames_bad, exp_ok, exp_bad);
        end
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            bq_t f = add_fcs(mk_raw($urandom_range(50, 150)));
            int  er_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 40)) : -1;
            int  base = cap.size();
            int  ne = eof_idx_q.size();
            int  ns = sof_idx_q.size();
            int  bad_bytes = 0;
            int  n;
            bit  eg;
            if ($urandom_range(0, 3) == 0) f[$urandom_range(0, f.size() - 1)] ^= 8'h10;
            n = f.size();
            eg = (n >= MIN_LEN) && (n <= MAX_LEN) && fcs_ok(f) && (er_at < 0);
            if (eg) exp_ok++; else exp_bad++;
            send(f, er_at, 3);
            for (int i = 0; i < n && base + i < cap.size(); i++)
                if (cap[base + i] !== f[i]) bad_bytes++;
            vectors++;
            if (cap.size() - base !== n || bad_bytes !== 0) begin
                errors++;
                $display("FAIL rand_data[%0d]: got %0d bytes (%0d wrong) want %0d",
                         it, cap.size() - base, bad_bytes, n);
            end
            vectors++;
            if (sof_idx_q.size() - ns !== 1 || sof_idx_q[$] !== base
                || eof_idx_q.size() - ne !== 1 || eof_idx_q[$] !== base + n - 1) begin
                errors++;
                $display("FAIL rand_marks[%0d]: got sof %0d eof %0d want %0d/%0d",
                         it, sof_idx_q[$], eof_idx_q[$], base, base + n - 1);
            end
            vectors++;
            if (eof_good_q[$] !== eg || eof_len_q[$] !== n) begin
                errors++;
                $display("FAIL rand_verdict[%0d]: got good=%0d len=%0d want %0d/%0d",
                         it, eof_good_q[$], eof_len_q[$], eg, n);
            end
            vectors++;
            if (int'(frames_ok) !== exp_ok || int'(frames_bad) !== exp_bad) begin
                errors++;
                $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d",
                         it, frames_ok, frames_bad, exp_ok, exp_bad);
            end
        end
    endtask

    task automatic test_short();
        bq_t f = add_fcs(mk_raw(56));
        int  ne = eof_idx_q.size();
        exp_bad++;
        send(f, -1, 3);
        vectors++;
        if (eof_idx_q.size() - ne !== 1 || eof_good_q[$] !== 1'b0 || eof_len_q[$] !== 60) begin
            errors++;
            $display("FAIL short_frame: got good=%0d len=%0d want 0/60",
                     eof_good_q[$], eof_len_q[$]);
        end
        vectors++;
        if (int'(frames_bad) !== exp_bad) begin
            errors++;
            $display("FAIL short_counter: got %0d want %0d", frames_bad, exp_bad);
        end
    endtask

    task automatic test_long();
        bq_t f = mk_raw(1600);
        int  base = cap.size();
        int  ne = eof_idx_q.size();
        exp_bad++;
        send(f, -1, 3);
        vectors++;
        if (cap.size() - base !== MAX_LEN) begin
            errors++;
            $display("FAIL long_count: got %0d want %0d", cap.size() - base, MAX_LEN);
        end
        vectors++;
        if (eof_idx_q.size() - ne !== 1 || eof_idx_q[$] !== base + MAX_LEN - 1
            || eof_good_q[$] !== 1'b0 || eof_len_q[$] !== MAX_LEN) begin
            errors++;
            $display("FAIL long_eof: got idx %0d good=%0d len=%0d want %0d/0/%0d",
                     eof_idx_q[$], eof_good_q[$], eof_len_q[$], base + MAX_LEN - 1, MAX_LEN);
        end
        vectors++;
        if (int'(frames_bad) !== exp_bad) begin
            errors++;
            $display("FAIL long_counter: got %0d want %0d", frames_bad, exp_bad);
        end
    endtask

    task automatic test_preamble();
        bq_t f = arp_frame();
        int  base = cap.size();
        int  ne = eof_idx_q.size();
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h5D);
        repeat (10) drive(1'b1, 1'b0, 8'($urandom));
        drive(1'b0, 1'b0, 8'h00);
        repeat (8) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        repeat (20) drive(1'b1, 1'b0, 8'($urandom));
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) drive(1'b1, 1'b0, 8'h55);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        vectors++;
        if (cap.size() !== base || int'(frames_ok) !== exp_ok || int'(frames_bad) !== exp_bad) begin
            errors++;
            $display("FAIL preamble_drop: got bytes=%0d ok=%0d bad=%0d want 0/%0d/%0d",
                     cap.size() - base, frames_ok, frames_bad, exp_ok, exp_bad);
        end
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h5D);
        drive(1'b0, 1'b0, 8'h00);
        exp_ok++;
        send(f, -1, 3);
        vectors++;
        if (cap.size() - base !== 64 || eof_idx_q.size() - ne !== 1 || eof_good_q[$] !== 1'b1) begin
            errors++;
            $display("FAIL preamble_recover: got bytes=%0d good=%0d want 64/1",
                     cap.size() - base, eof_good_q[$]);
        end
    endtask

    task automatic test_sfd_only();
        bq_t f;
        int  base = cap.size();
        exp_bad++;
        send(f, -1, 3);
        vectors++;
        if (cap.size() !== base || int'(frames_bad) !== exp_bad) begin
            errors++;
            $display("FAIL sfd_only: got bytes=%0d bad=%0d want 0/%0d",
                     cap.size() - base, frames_bad, exp_bad);
        end
    endtask

    task automatic test_rx_er();
        bq_t f = arp_frame();
        int  base = cap.size();
        exp_bad++;
        send(f, 10, 3);
        vectors++;
        if (cap.size() - base !== 64 || eof_good_q[$] !== 1'b0 || int'(frames_bad) !== exp_bad) begin
            errors++;
            $display("FAIL rx_er: got bytes=%0d good=%0d bad=%0d want 64/0/%0d",
                     cap.size() - base, eof_good_q[$], frames_bad, exp_bad);
        end
    endtask

    task automatic test_back_to_back();
        bq_t f1 = add_fcs(mk_raw($urandom_range(60, 100)));
        bq_t f2 = add_fcs(mk_raw($urandom_range(60, 100)));
        int  base = cap.size();
        int  ne = eof_idx_q.size();
        int  ns = sof_idx_q.size();
        exp_ok += 2;
        send(f1, -1, 1);
        send(f2, -1, 3);
        vectors++;
        if (cap.size() - base !== f1.size() + f2.size() || eof_idx_q.size() - ne !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d bytes want %0d",
                     cap.size() - base, f1.size() + f2.size());
        end
        vectors++;
        if (sof_idx_q.size() - ns !== 2 || sof_idx_q[$] !== base + f1.size()
            || eof_good_q[$] !== 1'b1 || eof_good_q[$-1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_marks: got sof2 %0d want %0d", sof_idx_q[$], base + f1.size());
        end
        vectors++;
        if (int'(frames_ok) !== exp_ok) begin
            errors++;
            $display("FAIL b2b_counter: got %0d want %0d", frames_ok, exp_ok);
        end
    endtask

    task automatic test_mid_reset();
        bq_t f = arp_frame();
        int  base;
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, f[i]);
        reset_n = 1'b0;
        for (int i = 20; i < 23; i++) drive(1'b1, 1'b0, f[i]);
        @(negedge clock);
        vectors++;
        if ({out_valid, out_sof, out_eof, out_good, out_data, out_len, frames_ok, frames_bad} !== 56'h0) begin
            errors++;
            $display("FAIL midreset_zero: got %h want 0",
                     {out_valid, out_sof, out_eof, out_good, out_data, out_len, frames_ok, frames_bad});
        end
        base = cap.size();
        exp_ok = 0;
        exp_bad = 0;
        reset_n = 1'b1;
        for (int i = 23; i < f.size(); i++) drive(1'b1, 1'b0, f[i]);
        drive(1'b0, 1'b0, 8'h00);
        exp_ok++;
        send(f, -1, 3);
        vectors++;
        if (cap.size() - base !== 64 || eof_good_q[$] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_next: got bytes=%0d good=%0d want 64/1",
                     cap.size() - base, eof_good_q[$]);
        end
        vectors++;
        if (frames_ok !== 16'd1 || frames_bad !== 16'd0) begin
            errors++;
            $display("FAIL midreset_counters: got %0d/%0d want 1/0", frames_ok, frames_bad);
        end
    endtask

    initial begin
        test_reset();
        test_arp(1'b0);
        test_arp(1'b1);
        test_short();
        test_long();
        test_preamble();
        test_sfd_only();
        test_rx_er();
        test_random(25);
        test_back_to_back();
        test_mid_reset();
        vectors++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL stray_markers: got %0d want 0", stray);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gmii_rx_frame.md
GMII_RX_FRAME -- requirements
Module: gmii_rx_frame

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum good frame length in bytes, DA through FCS inclusive.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum frame length in bytes, DA through FCS inclusive.
REQ-003 SHALL have port clock, input, 1 bit: PHY receive clock; all logic on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port rx_dv, input, 1 bit: GMII receive data valid.
REQ-006 SHALL have port rx_er, input, 1 bit: GMII receive error.
REQ-007 SHALL have port rx_data, input, 8 bits: GMII receive byte.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data carries a frame byte this cycle.
REQ-009 SHALL have port out_data, output, 8 bits: frame byte, DA first, FCS bytes included.
REQ-010 SHALL have port out_sof, output, 1 bit: first frame byte marker.
REQ-011 SHALL have port out_eof, output, 1 bit: last frame byte marker.
REQ-012 SHALL have port out_good, output, 1 bit: frame verdict, meaningful only while out_eof=1.
REQ-013 SHALL have port out_len, output, 12 bits: frame byte count, meaningful only while out_eof=1.
REQ-014 SHALL have port frames_ok, output, 16 bits: count of good frames, wraps 0xFFFF->0.
REQ-015 SHALL have port frames_bad, output, 16 bits: count of bad or aborted frames, wraps 0xFFFF->0.

Function
REQ-016 SHALL implement FSM states IDLE, PREAMBLE, DATA, DROP, with all outputs registered.
REQ-017 IDLE: rx_dv=1 with 0x55 -> PREAMBLE; rx_dv=1 with any other byte -> DROP; rx_dv=0 -> stay.
REQ-018 PREAMBLE: 0x55 -> stay; 0xD5 after 1..7 bytes of 0x55 -> DATA, CRC register loads 0xFFFFFFFF; any other byte, or an 8th 0x55 -> DROP; rx_dv=0 -> IDLE with no output and no counter change.
REQ-019 DATA: each byte sampled with rx_dv=1 enters a 1-byte holding register, updates the CRC and increments the length counter.
REQ-020 Latency: a byte sampled at edge k SHALL be driven on out_data from edge k+1 to edge k+2, out_valid=1; out_eof=1 when rx_dv=0 is sampled at edge k+1.
REQ-021 out_sof SHALL be 1 only with the first byte after the SFD; a 1-byte frame asserts out_sof and out_eof together.
REQ-022 CRC SHALL be reflected CRC-32, poly 0x04C11DB7, LSB-first, covering DA through FCS; the FCS is valid iff the final register equals 0xDEBB20E3.
REQ-023 out_good SHALL be 1 iff the FCS is valid, MIN_LEN <= length <= MAX_LEN, and rx_er was never sampled high in DATA.
REQ-024 An rx_er=1 sample in DATA SHALL mark the frame bad and the frame SHALL continue until rx_dv falls.
REQ-025 Byte number MAX_LEN+1 SHALL not be emitted; byte MAX_LEN is emitted with out_eof=1, out_good=0, out_len=MAX_LEN; FSM -> DROP.
REQ-026 SFD followed directly by rx_dv=0 SHALL produce no out_valid, SHALL increment frames_bad and -> IDLE.
REQ-027 At out_eof, frames_ok or frames_bad SHALL increment by exactly 1, on the same edge.
REQ-028 DROP SHALL emit nothing and -> IDLE on the first rx_dv=0 sample; one idle cycle between frames SHALL suffice.
REQ-029 out_valid, out_sof, out_eof and out_good SHALL be 0 on every non-data cycle.

Reset
REQ-030 While reset_n=0 all outputs, both counters, length and holding registers SHALL be 0 and the CRC register 0xFFFFFFFF.
REQ-031 The FSM SHALL leave reset in DROP, so a frame already in progress when reset deasserts is discarded without output or count.

Structure
REQ-032 Package gmii_rx_pkg SHALL hold the state enum, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_POLY, CRC_INIT and CRC_RESIDUE 0xDEBB20E3.
REQ-033 The byte-wide combinational CRC-32 next-state function SHALL be the sub-module crc32_d8, with inputs crc_in[31:0] and d[7:0] and output crc_out[31:0].

Verification
REQ-034 Broadcast ARP frame: 7x0x55, 0xD5, 60 bytes, correct FCS -> 64 out_valid, out_sof on 0xFF, out_eof on last FCS byte, out_good=1, out_len=64, frames_ok=1.
REQ-035 Same frame with byte 0x32 changed 0xDE->0xDF -> out_good=0, out_len=64, frames_bad=1.
REQ-036 56-byte frame with correct FCS (out_len=60) -> out_good=0, frames_bad increments.
REQ-037 rx_dv held for 1600 data bytes -> out_eof on byte 1518, out_good=0, no further out_valid until rx_dv=0 and the next frame.
REQ-038 Preamble 0x55, 0x55, 0x5D -> no output, FSM in DROP; next valid frame after a 1-cycle gap -> out_good=1.
REQ-039 reset_n=0 for 3 cycles at DATA byte 20 -> all outputs 0, rest of frame ignored, next frame out_good=1 with frames_ok=1.
